cnn_layer_accel_weight_seq_ctrl: RTL

Upstream driver and consumer of the weight sequence data table. For each kernel of a layer it walks the table indices 0..C_NUM_SEQ_VALUES-1 and captures the two returned sequence values per index. It adds the current kernel base to each value to form a pair of weight-buffer read addresses, and presents them on a valid/ready stream to the weight buffer read port. A 2-entry skid FIFO plus in-flight credit tracking absorbs the table's 1-cycle read latency under backpressure.

---
 rtl/cnn_layer_accel_weight_seq_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
// rtl/cnn_layer_accel_weight_seq_ctrl.sv - walks the weight sequence table per kernel and streams weight-buffer read address pairs
module cnn_layer_accel_weight_seq_ctrl #(
   parameter int C_NUM_SEQ_VALUES = 5,
   parameter int C_SEQ_WIDTH      = 4,
   parameter int C_RDADDR_WIDTH   = $clog2(C_NUM_SEQ_VALUES),
   parameter int C_WHT_ADDR_WIDTH = 10,
   parameter int C_NUM_KRNL_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [C_NUM_KRNL_WIDTH-1:0] num_kernels,
   input  logic [C_WHT_ADDR_WIDTH-1:0] base_addr,
   input  logic [C_WHT_ADDR_WIDTH-1:0] krnl_stride,
   output logic [C_RDADDR_WIDTH-1:0]   seq_rdAddr,
   output logic                        seq_rden,
   input  logic [C_SEQ_WIDTH-1:0]      seq_dout0,
   input  logic [C_SEQ_WIDTH-1:0]      seq_dout1,
   output logic [C_WHT_ADDR_WIDTH-1:0] wht_addr0,
   output logic [C_WHT_ADDR_WIDTH-1:0] wht_addr1,
   output logic                        wht_valid,
   input  logic                        wht_ready,
   output logic                        wht_last,
   output logic                        busy,
   output logic                        done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                      state, state_nxt;
   logic [C_NUM_KRNL_WIDTH-1:0] nk_r;
   logic [C_NUM_KRNL_WIDTH-1:0] kcnt;
   logic [C_WHT_ADDR_WIDTH-1:0] stride_r;
   logic [C_WHT_ADDR_WIDTH-1:0] kbase;
   logic [C_RDADDR_WIDTH-1:0]   idx;

   // request pipeline: base and last flag travel alongside the table read
   logic                        inflight;
   logic [C_WHT_ADDR_WIDTH-1:0] pipe_base;
   logic                        pipe_last;

   // 2-entry skid FIFO
   logic [C_WHT_ADDR_WIDTH-1:0] f_a0 [2];
   logic [C_WHT_ADDR_WIDTH-1:0] f_a1 [2];
   logic                        f_last [2];
   logic                        wr_ptr, rd_ptr;
   logic [1:0]                  fifo_cnt;

   logic                        pop, push, issue, last_idx, issue_last;
   logic [2:0]                  used;

   assign pop        = wht_valid & wht_ready;
   assign push       = inflight;
   // a pop this cycle frees a slot in time for the data returned by a read issued now
   assign used       = ({1'b0, fifo_cnt} + {2'b00, inflight}) - {2'b00, pop};
   assign issue      = (state == S_RUN) && (used < 3'd2);
   assign last_idx   = (idx == C_RDADDR_WIDTH'(C_NUM_SEQ_VALUES - 1));
   assign issue_last = last_idx && (kcnt == nk_r - 1'b1);

   assign seq_rdAddr = idx;
   assign seq_rden   = issue;
   assign wht_valid  = (fifo_cnt != 2'd0);
   assign wht_addr0  = f_a0[rd_ptr];
   assign wht_addr1  = f_a1[rd_ptr];
   assign wht_last   = wht_valid & f_last[rd_ptr];
   assign busy       = (state == S_RUN) || (state == S_DRAIN);
   assign done       = (state == S_DONE);

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // next-state logic; DRAIN exits as soon as the last pair leaves so done follows it by one cycle
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = (num_kernels == '0) ? S_DONE : S_RUN;
         S_RUN:   if (issue && issue_last) state_nxt = S_DRAIN;
         S_DRAIN: if (!inflight && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop)))
                     state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // parameter latch, table index and kernel base walk
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nk_r     <= '0;
         stride_r <= '0;
         kbase    <= '0;
         kcnt     <= '0;
         idx      <= '0;
      end else if ((state == S_IDLE) && start) begin
         nk_r     <= num_kernels;
         stride_r <= krnl_stride;
         kbase    <= base_addr;
         kcnt     <= '0;
         idx      <= '0;
      end else if (issue) begin
         if (last_idx) begin
            idx   <= '0;
            kcnt  <= kcnt + 1'b1;
            kbase <= kbase + stride_r;
         end else begin
            idx   <= idx + 1'b1;
         end
      end
   end

   // track the outstanding read and the context it was issued with
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight  <= 1'b0;
         pipe_base <= '0;
         pipe_last <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pipe_base <= kbase;
            pipe_last <= issue_last;
         end
      end
   end

   // skid FIFO: capture returned table data, release on handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            f_a0[i]   <= '0;
            f_a1[i]   <= '0;
            f_last[i] <= 1'b0;
         end
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (push) begin
            f_a0[wr_ptr]   <= pipe_base + C_WHT_ADDR_WIDTH'(seq_dout0);
            f_a1[wr_ptr]   <= pipe_base + C_WHT_ADDR_WIDTH'(seq_dout1);
            f_last[wr_ptr] <= pipe_last;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

endmodule
